// File: rtl/layer_out_serializer.sv
// layer_out_serializer
//   Collects the parallel outputs of one fully-connected layer (each neuron
//   pulses its own valid) and re-emits them as a contiguous serial stream,
//   one word per cycle in ascending neuron order. After each frame it
//   enforces exactly frameGap idle cycles so downstream neurons can finish
//   accumulating before the next frame arrives.
//
//   Optional feature macro: SER_DBUF_EN
//     defined   : separate capture and send buffers; the next frame may be
//                 captured while the current one is being sent.
//     undefined : the capture buffer is the send buffer; words arriving while
//                 a frame is being sent are dropped and flag overrun.
//
// Ports
//   clk             : clock, posedge
//   rst_n           : asynchronous active-low reset
//   neuron_out      : neuron i word at [i*dataWidth +: dataWidth]
//   neuron_valid    : bit i = valid pulse of neuron i
//   ovr_clr         : synchronous clear of overrun (a same-cycle set wins)
//   layer_out       : serial word to the next layer
//   layer_out_valid : qualifies layer_out
//   busy            : high while a frame is being sent or its gap runs
//   overrun         : sticky, a neuron word was dropped
module layer_out_serializer #(
  parameter int numNeurons = 10,
  parameter int dataWidth  = 16,
  parameter int frameGap   = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [numNeurons*dataWidth-1:0]  neuron_out,
  input  logic [numNeurons-1:0]            neuron_valid,
  input  logic                             ovr_clr,
  output logic [dataWidth-1:0]             layer_out,
  output logic                             layer_out_valid,
  output logic                             busy,
  output logic                             overrun
);

  localparam int IDXW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
  localparam int CW   = $clog2(frameGap + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(numNeurons - 1);
  localparam logic [CW-1:0]   GAP_LOAD = CW'(frameGap);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [numNeurons-1:0]   got_q, got_d;
  logic [dataWidth-1:0]    cap_q [numNeurons];
  logic [dataWidth-1:0]    cap_d [numNeurons];
`ifdef SER_DBUF_EN
  logic [dataWidth-1:0]    send_q [numNeurons];
  logic [dataWidth-1:0]    send_d [numNeurons];
`endif
  logic [dataWidth-1:0]    out_q, out_d;
  logic                    vld_q, vld_d;
  logic                    busy_q, busy_d;
  logic                    ovr_q, ovr_d;

  logic                    xfer;
  logic                    cap_open;
  logic [numNeurons-1:0]   free;
  logic [numNeurons-1:0]   accept;
  logic [numNeurons-1:0]   drop;

  // The FSM runs one cycle ahead of the registered outputs: the edge that
  // reads word idx is the edge that presents it, so state SEND here lines up
  // with the transfer edge + 1 and busy/valid are delayed copies of it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    xfer    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (&got_q) begin
          xfer    = 1'b1;
          state_d = SEND;
          idx_d   = '0;
        end
      end
      SEND: begin
`ifdef SER_DBUF_EN
        out_d = send_q[idx_q];
`else
        out_d = cap_q[idx_q];
`endif
        vld_d = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      GAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_ONE) begin
          if (&got_q) begin
            xfer    = 1'b1;
            state_d = SEND;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_q != IDLE);
  end

  // Capture. In single-buffer mode the buffer is also being read from the
  // transfer edge until the last word is presented, so writes are refused
  // over that whole window, not just while the FSM sits in SEND.
  always_comb begin
`ifdef SER_DBUF_EN
    cap_open = 1'b1;
`else
    cap_open = (state_q != SEND) && !vld_q && !xfer;
`endif
    free   = xfer ? '1 : ~got_q;
    accept = cap_open ? (neuron_valid & free) : '0;
    drop   = neuron_valid & ~accept;
    got_d  = (xfer ? '0 : got_q) | accept;
    for (int unsigned i = 0; i < numNeurons; i++) begin
      cap_d[i] = accept[i] ? neuron_out[i*dataWidth +: dataWidth] : cap_q[i];
`ifdef SER_DBUF_EN
      send_d[i] = xfer ? cap_q[i] : send_q[i];
`endif
    end
    if (|drop) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      got_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      got_q   <= got_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  // Word storage needs no reset: got_q decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < numNeurons; i++) begin
      cap_q[i] <= cap_d[i];
`ifdef SER_DBUF_EN
      send_q[i] <= send_d[i];
`endif
    end
  end

  assign layer_out       = out_q;
  assign layer_out_valid = vld_q;
  assign busy            = busy_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
module tb_layer_out_serializer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int G  = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*DW-1:0]   neuron_out;
  logic [N-1:0]      neuron_valid;
  logic              ovr_clr;
  logic [DW-1:0]     layer_out;
  logic              layer_out_valid;
  logic              busy;
  logic              overrun;

  always #5 clk = ~clk;

  layer_out_serializer #(
    .numNeurons(N),
    .dataWidth (DW),
    .frameGap  (G)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .neuron_out     (neuron_out),
    .neuron_valid   (neuron_valid),
    .ovr_clr        (ovr_clr),
    .layer_out      (layer_out),
    .layer_out_valid(layer_out_valid),
    .busy           (busy),
    .overrun        (overrun)
  );

  // Reference model: frames are tracked by the edge of their first word;
  // output validity and busy follow from that edge, N and G.
  logic [DW-1:0] m_cap  [N];
  logic [DW-1:0] m_send [N];
  bit            m_got  [N];
  bit            m_ovr;
  logic [DW-1:0] m_out;
  int            start_e;
  int            prev_end;
  int            cyc;
  int            checks;
  int            errors;
  int            rec_cyc[$];
  logic [DW-1:0] rec_word[$];

  function automatic bit exp_vld();
    return (cyc >= start_e) && (cyc <= start_e + N - 1);
  endfunction

  function automatic bit exp_busy();
    return ((cyc >= start_e) && (cyc <= start_e + N - 1 + G)) || (cyc <= prev_end);
  endfunction

  function automatic logic [N*DW-1:0] pack(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic model_reset();
    start_e  = -1000;
    prev_end = -1000;
    m_ovr    = 1'b0;
    m_out    = '0;
    for (int i = 0; i < N; i++) m_got[i] = 1'b0;
  endtask

  task automatic model_edge(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic clr);
    bit complete;
    bit xfer;
    bit open;
    bit dropped;
    complete = 1'b1;
    for (int i = 0; i < N; i++) if (!m_got[i]) complete = 1'b0;
    xfer = complete && (cyc >= start_e + N - 1 + G);
    if (xfer) begin
      prev_end = start_e + N - 1 + G;
      for (int i = 0; i < N; i++) begin
        m_send[i] = m_cap[i];
        m_got[i]  = 1'b0;
      end
      start_e = cyc + 1;
    end
`ifdef SER_DBUF_EN
    open = 1'b1;
`else
    open = !((cyc >= start_e - 1) && (cyc <= start_e + N));
`endif
    dropped = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (open && !m_got[i]) begin
          m_got[i] = 1'b1;
          m_cap[i] = d[i*DW +: DW];
        end else begin
          dropped = 1'b1;
        end
      end
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (exp_vld()) m_out = m_send[cyc - start_e];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("valid",   32'(layer_out_valid), 32'(exp_vld()));
    chk("data",    32'(layer_out),       32'(m_out));
    chk("busy",    32'(busy),            32'(exp_busy()));
    chk("overrun", 32'(overrun),         32'(m_ovr));
  endtask

  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic clr);
    neuron_valid = v;
    neuron_out   = d;
    ovr_clr      = clr;
    @(posedge clk);
    cyc++;
    model_edge(v, d, clr);
    #1;
    check_all();
    if (layer_out_valid === 1'b1) begin
      rec_cyc.push_back(cyc);
      rec_word.push_back(layer_out);
    end
    neuron_valid = '0;
    ovr_clr      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, '0, 1'b0);
  endtask

  task automatic clear_rec();
    rec_cyc.delete();
    rec_word.delete();
  endtask

  int base;
  logic [N*DW-1:0] rd;

  initial begin
    checks       = 0;
    errors       = 0;
    cyc          = 0;
    rst_n        = 1'b0;
    neuron_valid = '0;
    neuron_out   = '0;
    ovr_clr      = 1'b0;
    model_reset();
    #2;
    chk("rst_data",    32'(layer_out),       32'h0);
    chk("rst_valid",   32'(layer_out_valid), 32'h0);
    chk("rst_busy",    32'(busy),            32'h0);
    chk("rst_overrun", 32'(overrun),         32'h0);
    #20;
    rst_n = 1'b1;
    idle(2);

    // T1: all valid together
    clear_rec();
    step('1, pack(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b0);
    base = cyc;
    idle(16);
    chk("t1_count", 32'(rec_cyc.size()), 32'd4);
    if (rec_cyc.size() == 4) begin
      chk("t1_first", 32'(rec_cyc[0] - base), 32'd2);
      for (int k = 0; k < 4; k++) chk("t1_word", 32'(rec_word[k]), 32'(k + 1));
    end

    // T2: skewed valids
    clear_rec();
    step(4'b0100, pack(16'h0, 16'h0, 16'h00AA, 16'h0), 1'b0);
    base = cyc;
    idle(2);
    step(4'b1011, pack(16'h0011, 16'h0011, 16'h0, 16'h0011), 1'b0);
    idle(16);
    chk("t2_count", 32'(rec_cyc.size()), 32'd4);
    if (rec_cyc.size() == 4) begin
      chk("t2_first", 32'(rec_cyc[0] - base), 32'd5);
      chk("t2_w2",    32'(rec_word[2]),       32'h00AA);
      chk("t2_w3",    32'(rec_word[3]),       32'h0011);
    end
    chk("t2_ovr", 32'(overrun), 32'h0);

    // T3/T4: second frame arrives while the first is being sent
    clear_rec();
    step('1, pack(16'h0021, 16'h0022, 16'h0023, 16'h0024), 1'b0);
    idle(2);
    step('1, pack(16'h0031, 16'h0032, 16'h0033, 16'h0034), 1'b0);
    idle(24);
`ifdef SER_DBUF_EN
    chk("t4_count", 32'(rec_cyc.size()), 32'd8);
    if (rec_cyc.size() == 8) begin
      chk("t4_gap", 32'(rec_cyc[4] - rec_cyc[3]), 32'(G + 1));
      chk("t4_w4",  32'(rec_word[4]),             32'h0031);
    end
    chk("t4_ovr", 32'(overrun), 32'h0);
`else
    chk("t3_count", 32'(rec_cyc.size()), 32'd4);
    chk("t3_ovr",   32'(overrun),        32'h1);
    step('0, '0, 1'b1);
    chk("t3_clr",   32'(overrun),        32'h0);
`endif

    // T5: duplicate valid on neuron 1
    clear_rec();
    step(4'b0010, pack(16'h0, 16'h0005, 16'h0, 16'h0), 1'b0);
    step(4'b0010, pack(16'h0, 16'h0007, 16'h0, 16'h0), 1'b0);
    step(4'b1101, pack(16'h0050, 16'h0, 16'h0052, 16'h0053), 1'b0);
    idle(16);
    chk("t5_ovr", 32'(overrun), 32'h1);
    if (rec_word.size() == 4) chk("t5_w1", 32'(rec_word[1]), 32'h0005);
    else chk("t5_count", 32'(rec_word.size()), 32'd4);
    step('0, '0, 1'b1);

    // T6: asynchronous reset while word 2 is on the bus
    clear_rec();
    step('1, pack(16'h0061, 16'h0062, 16'h0063, 16'h0064), 1'b0);
    idle(4);
    chk("t6_pre", 32'(layer_out), 32'h0063);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(layer_out_valid), 32'h0);
    chk("t6_data",  32'(layer_out),       32'h0);
    chk("t6_busy",  32'(busy),            32'h0);
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    check_all();
    #2;
    rst_n = 1'b1;
    clear_rec();
    idle(20);
    chk("t6_quiet", 32'(rec_cyc.size()), 32'd0);
    step('1, pack(16'h0071, 16'h0072, 16'h0073, 16'h0074), 1'b0);
    idle(16);
    chk("t6_new", 32'(rec_cyc.size()), 32'd4);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) rd[i*DW +: DW] = DW'($urandom);
      step(N'($urandom_range(0, 15) & $urandom_range(0, 15)), rd,
           1'($urandom_range(0, 9) == 0));
    end
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
